// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin writeback arbiter for the register file write port with a RAW scoreboard
module regfile_wb_arbiter #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    rf_write,
   output logic [ADDR_W-1:0]       rf_addr,
   output logic [DATA_W-1:0]       rf_data,
   input  logic                    rsv_valid,
   input  logic [ADDR_W-1:0]       rsv_addr,
   output logic                    rsv_ready,
   input  logic [ADDR_W-1:0]       qry_addr1,
   input  logic [ADDR_W-1:0]       qry_addr2,
   output logic                    qry_busy1,
   output logic                    qry_busy2
);
   localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int NREG = 2 ** ADDR_W;
   logic [PW-1:0]     rr_ptr;
   logic [PW-1:0]     g;
   logic              gnt;
   int                idx;
   logic [NREG-1:0]   busy;
   logic [NREG-1:0]   busy_nxt;
   logic [ADDR_W-1:0] g_addr;
   logic [DATA_W-1:0] g_data;
   // scan downward so the lowest offset from rr_ptr wins
   always_comb begin
      g   = rr_ptr;
      gnt = 1'b0;
      idx = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr) + k) % N_REQ;
         if (req_valid[idx]) begin
            g   = PW'(idx);
            gnt = ~reset;
         end
      end
   end
   assign req_ready = gnt ? N_REQ'(1) << g : '0;
   assign g_addr    = req_addr[g*ADDR_W +: ADDR_W];
   assign g_data    = req_data[g*DATA_W +: DATA_W];
   assign rsv_ready = rsv_valid & ~busy[rsv_addr] & ~reset;
   assign qry_busy1 = busy[qry_addr1];
   assign qry_busy2 = busy[qry_addr2];
   // a reservation of a register being cleared this cycle is already refused by rsv_ready
   always_comb begin
      busy_nxt = busy;
      if (gnt) busy_nxt[g_addr] = 1'b0;
      if (rsv_ready) busy_nxt[rsv_addr] = 1'b1;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_write <= 1'b0;
         rf_addr  <= '0;
         rf_data  <= '0;
         busy     <= '0;
         rr_ptr   <= '0;
      end else begin
         rf_write <= gnt;
         busy     <= busy_nxt;
         if (gnt) begin
            rf_addr <= g_addr;
            rf_data <= g_data;
            rr_ptr  <= (g == PW'(N_REQ - 1)) ? '0 : g + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: randomized and directed checks against a behavioural arbiter/scoreboard model
module tb_regfile_wb_arbiter;
   localparam int N = 4, AW = 4, DW = 8;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    req_ready;
   logic            rf_write;
   logic [AW-1:0]   rf_addr;
   logic [DW-1:0]   rf_data;
   logic            rsv_valid = 1'b0;
   logic [AW-1:0]   rsv_addr = '0;
   logic            rsv_ready;
   logic [AW-1:0]   qry_addr1 = '0;
   logic [AW-1:0]   qry_addr2 = '0;
   logic            qry_busy1, qry_busy2;
   int passed = 0, total = 0;
   int m_ptr = 0;
   logic [15:0] m_busy = '0;
   logic        m_wr = 1'b0;
   logic [3:0]  m_addr = '0;
   logic [7:0]  m_data = '0;

   regfile_wb_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
      .req_ready(req_ready), .rf_write(rf_write), .rf_addr(rf_addr), .rf_data(rf_data),
      .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
      .qry_addr1(qry_addr1), .qry_addr2(qry_addr2), .qry_busy1(qry_busy1), .qry_busy2(qry_busy2)
   );

   always #5 clk = ~clk;

   function automatic int model_grant();
      if (reset) return -1;
      for (int k = 0; k < N; k++) if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   function automatic logic [3:0] exp_ready();
      int g = model_grant();
      return (g < 0) ? 4'b0000 : 4'(1 << g);
   endfunction

   function automatic logic exp_rsv();
      return !reset && rsv_valid && !m_busy[rsv_addr];
   endfunction

   task automatic set_req(input int i, input logic v, input logic [3:0] a, input logic [7:0] d);
      req_valid[i]        = v;
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   // one clock: capture model decisions from the inputs, advance the model past the edge
   task automatic step();
      int g = model_grant();
      logic rok = exp_rsv();
      logic [3:0] ra = rsv_addr;
      logic [3:0] ga = (g >= 0) ? req_addr[g*AW +: AW] : 4'd0;
      logic [7:0] gd = (g >= 0) ? req_data[g*DW +: DW] : 8'd0;
      @(posedge clk);
      if (reset) begin
         m_ptr = 0; m_busy = '0; m_wr = 0; m_addr = 0; m_data = 0;
      end else begin
         m_wr = (g >= 0);
         if (g >= 0) begin
            m_addr = ga; m_data = gd; m_ptr = (g + 1) % N; m_busy[ga] = 1'b0;
         end
         if (rok) m_busy[ra] = 1'b1;
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1; req_valid = 4'b1111; rsv_valid = 1; rsv_addr = 4'd2;
      #1;
      total++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b want 0000", req_ready); else passed++;
      total++; if (rsv_ready !== 1'b0) $display("FAIL reset_rsv_ready: got %b want 0", rsv_ready); else passed++;
      step(); step();
      total++; if (rf_write !== 1'b0) $display("FAIL reset_rf_write: got %b want 0", rf_write); else passed++;
      total++; if (rf_addr !== 4'd0 || rf_data !== 8'd0) $display("FAIL reset_rf_addr_data: got %h/%h want 0/0", rf_addr, rf_data); else passed++;
      reset = 0; req_valid = '0; rsv_valid = 0;
      for (int a = 0; a < 16; a += 2) begin
         qry_addr1 = 4'(a); qry_addr2 = 4'(a + 1); #1;
         total++; if (qry_busy1 !== 1'b0 || qry_busy2 !== 1'b0) $display("FAIL reset_busy%0d: got %b%b want 00", a, qry_busy1, qry_busy2); else passed++;
      end
   endtask

   task automatic test_single();
      set_req(0, 1, 4'd3, 8'hA5); #1;
      total++; if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b want 0001", req_ready); else passed++;
      step();
      req_valid = '0; #1;
      total++; if (rf_write !== 1'b1 || rf_addr !== 4'd3 || rf_data !== 8'hA5) $display("FAIL single_write: got %b/%h/%h want 1/3/a5", rf_write, rf_addr, rf_data); else passed++;
      step();
      total++; if (rf_write !== 1'b0 || rf_addr !== 4'd3) $display("FAIL single_pulse: got %b/%h want 0/3", rf_write, rf_addr); else passed++;
   endtask

   task automatic test_fairness();
      logic [7:0] d [N];
      reset = 1; step(); reset = 0;
      for (int i = 0; i < N; i++) begin
         d[i] = 8'($urandom);
         set_req(i, 1, 4'(i + 8), d[i]);
      end
      for (int k = 0; k < 2 * N; k++) begin
         #1;
         total++; if (req_ready !== 4'(1 << (k % N))) $display("FAIL fair_grant%0d: got %b want %b", k, req_ready, 4'(1 << (k % N))); else passed++;
         step();
         total++; if (rf_write !== 1'b1 || rf_data !== d[k % N] || rf_addr !== 4'(k % N + 8)) $display("FAIL fair_data%0d: got %b/%h/%h want 1/%h/%h", k, rf_write, rf_addr, rf_data, 4'(k % N + 8), d[k % N]); else passed++;
      end
      req_valid = '0; step();
   endtask

   task automatic test_scoreboard();
      rsv_valid = 1; rsv_addr = 4'd5; qry_addr1 = 4'd5; #1;
      total++; if (rsv_ready !== 1'b1) $display("FAIL sb_rsv_accept: got %b want 1", rsv_ready); else passed++;
      step();
      total++; if (qry_busy1 !== 1'b1) $display("FAIL sb_busy_set: got %b want 1", qry_busy1); else passed++;
      total++; if (rsv_ready !== 1'b0) $display("FAIL sb_rsv_refuse: got %b want 0", rsv_ready); else passed++;
      step();
      rsv_valid = 0; set_req(1, 1, 4'd5, 8'h3C); #1;
      total++; if (req_ready !== 4'b0010) $display("FAIL sb_wr_ready: got %b want 0010", req_ready); else passed++;
      total++; if (qry_busy1 !== 1'b1) $display("FAIL sb_busy_at_grant: got %b want 1", qry_busy1); else passed++;
      step();
      req_valid = '0; #1;
      total++; if (qry_busy1 !== 1'b0) $display("FAIL sb_busy_clear: got %b want 0", qry_busy1); else passed++;
   endtask

   task automatic test_same_cycle();
      rsv_valid = 1; rsv_addr = 4'd7; qry_addr2 = 4'd7; step();
      set_req(3, 1, 4'd7, 8'h77); #1;
      total++; if (qry_busy2 !== 1'b1 || rsv_ready !== 1'b0) $display("FAIL same_refuse: got busy=%b rdy=%b want 1/0", qry_busy2, rsv_ready); else passed++;
      total++; if (req_ready !== 4'b1000) $display("FAIL same_wr_ready: got %b want 1000", req_ready); else passed++;
      step();
      req_valid = '0; #1;
      total++; if (qry_busy2 !== 1'b0 || rsv_ready !== 1'b1) $display("FAIL same_retry: got busy=%b rdy=%b want 0/1", qry_busy2, rsv_ready); else passed++;
      step();
      rsv_valid = 0; #1;
      total++; if (qry_busy2 !== 1'b1) $display("FAIL same_reserved: got %b want 1", qry_busy2); else passed++;
   endtask

   task automatic test_reset_mid();
      rsv_valid = 1; rsv_addr = 4'd9; qry_addr1 = 4'd9; step();
      rsv_valid = 0; set_req(1, 1, 4'd1, 8'h11); step();
      req_valid = '0; set_req(2, 1, 4'd2, 8'h22); set_req(0, 1, 4'd4, 8'h44); reset = 1; #1;
      total++; if (req_ready !== 4'b0000) $display("FAIL rstmid_ready: got %b want 0000", req_ready); else passed++;
      step();
      reset = 0; #1;
      total++; if (rf_write !== 1'b0 || qry_busy1 !== 1'b0) $display("FAIL rstmid_state: got wr=%b busy=%b want 0/0", rf_write, qry_busy1); else passed++;
      total++; if (req_ready !== 4'b0001) $display("FAIL rstmid_ptr: got %b want 0001", req_ready); else passed++;
      req_valid = '0; step();
   endtask

   task automatic test_random();
      logic [N-1:0] pv = '0;
      for (int c = 0; c < 400; c++) begin
         int g;
         for (int i = 0; i < N; i++)
            if (!pv[i] && $urandom_range(0, 2) != 0) begin
               pv[i] = 1; set_req(i, 1, 4'($urandom), 8'($urandom));
            end
         req_valid = pv;
         reset     = ($urandom_range(0, 49) == 0);
         rsv_valid = $urandom_range(0, 1);
         rsv_addr  = 4'($urandom);
         qry_addr1 = 4'($urandom);
         qry_addr2 = 4'($urandom);
         #1;
         total++; if (req_ready !== exp_ready()) $display("FAIL rnd_ready c%0d: got %b want %b", c, req_ready, exp_ready()); else passed++;
         total++; if (rsv_ready !== exp_rsv()) $display("FAIL rnd_rsv c%0d: got %b want %b", c, rsv_ready, exp_rsv()); else passed++;
         total++; if (qry_busy1 !== m_busy[qry_addr1] || qry_busy2 !== m_busy[qry_addr2]) $display("FAIL rnd_qry c%0d: got %b%b want %b%b", c, qry_busy1, qry_busy2, m_busy[qry_addr1], m_busy[qry_addr2]); else passed++;
         g = model_grant();
         if (g >= 0) pv[g] = 0;
         step();
         total++; if (rf_write !== m_wr || rf_addr !== m_addr || rf_data !== m_data) $display("FAIL rnd_write c%0d: got %b/%h/%h want %b/%h/%h", c, rf_write, rf_addr, rf_data, m_wr, m_addr, m_data); else passed++;
      end
      reset = 0; req_valid = '0; rsv_valid = 0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_scoreboard();
      test_same_cycle();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
